// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types, encodings and defaults for the MIPS control sequencer
package mips_cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic writes_rd;
    logic writes_rt;
    logic valid;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_cpu_decode.sv
// rtl/mips_cpu_decode.sv - combinational instruction word to control bundle decoder
// Ports:
//   ir   in  32  latched instruction word
//   ctrl out     control bundle; valid=0 marks an encoding executed as NOP
module mips_cpu_decode
  import mips_cpu_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (ir[31:26])
      OP_RTYPE: begin
        unique case (ir[5:0])
          FN_JR: begin
            ctrl.is_jump = 1'b1;
            ctrl.valid   = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: begin
            ctrl.writes_rd = 1'b1;
            ctrl.valid     = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: begin
        ctrl.is_jump = 1'b1;
        ctrl.valid   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.is_branch = 1'b1;
        ctrl.valid     = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl.writes_rt = 1'b1;
        ctrl.valid     = 1'b1;
      end
      OP_LW: begin
        ctrl.is_load   = 1'b1;
        ctrl.writes_rt = 1'b1;
        ctrl.valid     = 1'b1;
      end
      OP_SW: begin
        ctrl.is_store = 1'b1;
        ctrl.valid    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_ctrl_fsm.sv
// rtl/mips_cpu_ctrl_fsm.sv - multi-cycle MIPS control sequencer (fetch/decode/exec/mem/wb)
// Ports:
//   clk, reset_n                    core clock, async active-low reset
//   active                          high while executing instructions
//   instr_*                         instruction fetch bus (address, read, readdata, waitrequest)
//   data_*                          load/store bus (address, read, write, writedata, readdata, waitrequest)
//   rf_read_a/b, rf_data_a/b        register file async read ports (rs, rt)
//   rf_write_en/addr/data           register file writeback
//   alu_*                           operands/controls to the shared ALU, alu_result back
module mips_cpu_ctrl_fsm
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        active,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic [31:0] instr_readdata,
  input  logic        instr_waitrequest,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest,
  output logic [4:0]  rf_read_a,
  output logic [4:0]  rf_read_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_control,
  output logic [4:0]  alu_shamt,
  output logic [15:0] alu_immediate,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  input  logic [31:0] alu_result
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, rs_q, rt_q, res_q, ld_q, addr_q, tgt_q;
  logic        pending_q;

  ctrl_t       ctrl;
  logic        retire;
  logic [31:0] pc_plus4, imm_sext, br_target, j_target, redirect_target, next_pc;
  logic        branch_cond, redirect;
  logic [4:0]  wb_addr;
  logic        wb_allowed;

  mips_cpu_decode u_decode (
    .ir   (ir_q),
    .ctrl (ctrl)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign imm_sext  = sext16(ir_q[15:0]);
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  assign branch_cond = (ir_q[31:26] == OP_BEQ) ? (rs_q == rt_q) : (rs_q != rt_q);
  assign redirect    = ctrl.valid && (ctrl.is_jump || (ctrl.is_branch && branch_cond));

  // The only R-type jump is jr; everything else with is_jump is j.
  always_comb begin
    if (ctrl.is_branch)                 redirect_target = br_target;
    else if (ir_q[31:26] == OP_RTYPE)   redirect_target = rs_q;
    else                                redirect_target = j_target;
  end

  // A pending redirect belongs to the previous instruction; this one is its delay slot.
  assign next_pc = pending_q ? tgt_q : pc_plus4;

  assign wb_addr    = ctrl.writes_rd ? ir_q[15:11] : ir_q[20:16];
  assign wb_allowed = (ctrl.writes_rd || ctrl.writes_rt) && (wb_addr != 5'd0);

  assign rf_read_a = ir_q[25:21];
  assign rf_read_b = ir_q[20:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    active         = 1'b0;
    instr_read     = 1'b0;
    instr_address  = 32'd0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_address   = 32'd0;
    data_writedata = 32'd0;
    rf_write_en    = 1'b0;
    rf_write_addr  = 5'd0;
    rf_write_data  = 32'd0;
    alu_opcode     = 6'd0;
    alu_control    = 6'd0;
    alu_shamt      = 5'd0;
    alu_immediate  = 16'd0;
    alu_rs         = 32'd0;
    alu_rt         = 32'd0;

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        active        = 1'b1;
        instr_read    = 1'b1;
        instr_address = pc_q;
        if (!instr_waitrequest) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        active  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        active        = 1'b1;
        alu_opcode    = ir_q[31:26];
        alu_control   = ir_q[5:0];
        alu_shamt     = ir_q[10:6];
        alu_immediate = ir_q[15:0];
        alu_rs        = rs_q;
        alu_rt        = rt_q;
        if (!ctrl.valid)                          retire  = 1'b1;
        else if (ctrl.is_load || ctrl.is_store)   state_d = ST_MEM;
        else if (ctrl.is_branch || ctrl.is_jump)  retire  = 1'b1;
        else                                      state_d = ST_WB;
      end
      ST_MEM: begin
        active       = 1'b1;
        data_address = addr_q;
        if (ctrl.is_store) begin
          data_write     = 1'b1;
          data_writedata = rt_q;
        end else begin
          data_read = 1'b1;
        end
        if (!data_waitrequest) begin
          if (ctrl.is_store) retire  = 1'b1;
          else               state_d = ST_WB;
        end
      end
      ST_WB: begin
        active        = 1'b1;
        rf_write_en   = wb_allowed;
        rf_write_addr = wb_addr;
        rf_write_data = ctrl.is_load ? ld_q : res_q;
        retire        = 1'b1;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    if (retire) state_d = (next_pc == HALT_ADDR) ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_VECTOR;
      ir_q      <= 32'd0;
      rs_q      <= 32'd0;
      rt_q      <= 32'd0;
      res_q     <= 32'd0;
      ld_q      <= 32'd0;
      addr_q    <= 32'd0;
      tgt_q     <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      if (state_q == ST_FETCH && !instr_waitrequest) ir_q <= instr_readdata;
      if (state_q == ST_DECODE) begin
        rs_q <= rf_data_a;
        rt_q <= rf_data_b;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= alu_result;
        addr_q <= rs_q + imm_sext;
      end
      if (state_q == ST_MEM && !data_waitrequest && ctrl.is_load) ld_q <= data_readdata;
      if (retire) begin
        pc_q <= next_pc;
        if (pending_q) begin
          // Delay slot retires: take the redirect; a branch here is ignored.
          pending_q <= 1'b0;
        end else if (state_q == ST_EXEC && redirect) begin
          pending_q <= 1'b1;
          tgt_q     <= redirect_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// tb/tb_mips_cpu_ctrl_fsm.sv - directed self-checking bench for mips_cpu_ctrl_fsm
module tb_mips_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        active;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [4:0]  rf_read_a, rf_read_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [5:0]  alu_opcode, alu_control;
  logic [4:0]  alu_shamt;
  logic [15:0] alu_immediate;
  logic [31:0] alu_rs, alu_rt;
  logic [31:0] alu_result;

  logic [31:0] imem [0:15];
  logic [31:0] rf   [0:31];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_ctrl_fsm dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .active            (active),
    .instr_address     (instr_address),
    .instr_read        (instr_read),
    .instr_readdata    (instr_readdata),
    .instr_waitrequest (instr_waitrequest),
    .data_address      (data_address),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_writedata    (data_writedata),
    .data_readdata     (data_readdata),
    .data_waitrequest  (data_waitrequest),
    .rf_read_a         (rf_read_a),
    .rf_read_b         (rf_read_b),
    .rf_data_a         (rf_data_a),
    .rf_data_b         (rf_data_b),
    .rf_write_en       (rf_write_en),
    .rf_write_addr     (rf_write_addr),
    .rf_write_data     (rf_write_data),
    .alu_opcode        (alu_opcode),
    .alu_control       (alu_control),
    .alu_shamt         (alu_shamt),
    .alu_immediate     (alu_immediate),
    .alu_rs            (alu_rs),
    .alu_rt            (alu_rt),
    .alu_result        (alu_result)
  );

  assign instr_readdata = imem[instr_address[5:2]];
  assign rf_data_a      = rf[rf_read_a];
  assign rf_data_b      = rf[rf_read_b];

  always @(posedge clk) if (rf_write_en) rf[rf_write_addr] <= rf_write_data;

  // Minimal ALU: only the operations the vectors use.
  always_comb begin
    alu_result = 32'd0;
    if (alu_opcode == 6'h09) alu_result = alu_rs + {{16{alu_immediate[15]}}, alu_immediate};
    else if (alu_opcode == 6'h00 && alu_control == 6'h21) alu_result = alu_rs + alu_rt;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_state();
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0000;
    for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    data_waitrequest  = 1'b0;
    instr_waitrequest = 1'b0;
    data_readdata     = 32'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_state();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", active); end
    checks++; if (instr_read !== 1'b0 || instr_address !== 32'd0) begin errors++; $display("FAIL reset_fetch got %b/%h exp 0/0", instr_read, instr_address); end
    checks++; if (data_read !== 1'b0 || data_write !== 1'b0 || data_address !== 32'd0) begin errors++; $display("FAIL reset_data got %b%b/%h exp 00/0", data_read, data_write, data_address); end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_wb got %b exp 0", rf_write_en); end
  endtask

  task automatic test_alu_addiu();
    clear_state();
    imem[0] = 32'h2401_0005;
    do_reset();
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0000) begin errors++; $display("FAIL addiu_fetch got %b/%h exp 1/bfc00000", instr_read, instr_address); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL addiu_active got %b exp 1", active); end
    tick(); tick(); tick();
    checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd1 || rf_write_data !== 32'd5) begin errors++; $display("FAIL addiu_wb got %b/%0d/%h exp 1/1/5", rf_write_en, rf_write_addr, rf_write_data); end
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL addiu_next_fetch got %b/%h exp 1/bfc00004", instr_read, instr_address); end
    checks++; if (rf[1] !== 32'd5) begin errors++; $display("FAIL addiu_rf got %h exp 5", rf[1]); end
  endtask

  task automatic test_lw_wait();
    clear_state();
    rf[1] <= 32'h0000_0100;
    imem[0] = 32'h8C22_0004;
    data_readdata    = 32'hDEAD_BEEF;
    data_waitrequest = 1'b1;
    do_reset();
    tick();
    checks++; if (instr_address !== 32'hBFC0_0000) begin errors++; $display("FAIL lw_fetch got %h exp bfc00000", instr_address); end
    tick(); tick();
    for (int c = 4; c <= 7; c++) begin
      tick();
      checks++;
      if (data_read !== 1'b1 || data_address !== 32'h0000_0104 || rf_write_en !== 1'b0) begin
        errors++; $display("FAIL lw_mem_c%0d got rd=%b addr=%h we=%b exp 1/104/0", c, data_read, data_address, rf_write_en);
      end
      if (c == 7) data_waitrequest = 1'b0;
    end
    tick();
    checks++; if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd2 || rf_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb got %b/%0d/%h exp 1/2/deadbeef", rf_write_en, rf_write_addr, rf_write_data); end
    checks++; if (data_read !== 1'b0) begin errors++; $display("FAIL lw_wb_strobe got %b exp 0", data_read); end
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL lw_next_fetch got %b/%h exp 1/bfc00004", instr_read, instr_address); end
  endtask

  task automatic test_branch_delay_slot();
    clear_state();
    imem[0] = 32'h1000_0003;
    do_reset();
    tick();
    checks++; if (instr_address !== 32'hBFC0_0000) begin errors++; $display("FAIL beq_fetch got %h exp bfc00000", instr_address); end
    tick(); tick();
    checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL beq_exec_read got %b exp 0", instr_read); end
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL beq_slot_fetch got %b/%h exp 1/bfc00004", instr_read, instr_address); end
    repeat (4) tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0010) begin errors++; $display("FAIL beq_target_fetch got %b/%h exp 1/bfc00010", instr_read, instr_address); end
  endtask

  task automatic test_jr_halt();
    int strobes;
    clear_state();
    imem[0] = 32'h03E0_0008;
    do_reset();
    repeat (4) tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL jr_slot_fetch got %b/%h exp 1/bfc00004", instr_read, instr_address); end
    repeat (4) tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL jr_halt_active got %b exp 0", active); end
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      if (instr_read || data_read || data_write || rf_write_en || active) strobes++;
      tick();
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL jr_halt_quiet got %0d active cycles exp 0", strobes); end
  endtask

  task automatic test_addu_zero_dest();
    clear_state();
    rf[1] <= 32'd7;
    imem[0] = 32'h0021_0021;
    do_reset();
    repeat (4) tick();
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL addu_r0_we got %b exp 0", rf_write_en); end
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL addu_r0_next got %b/%h exp 1/bfc00004", instr_read, instr_address); end
  endtask

  task automatic test_unknown_opcode();
    int busy;
    clear_state();
    imem[0] = 32'hFC00_0000;
    do_reset();
    tick();
    busy = 0;
    for (int c = 2; c <= 3; c++) begin
      tick();
      if (instr_read || data_read || data_write || rf_write_en) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL unk_quiet got %0d busy cycles exp 0", busy); end
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0004) begin errors++; $display("FAIL unk_next_fetch got %b/%h exp 1/bfc00004", instr_read, instr_address); end
  endtask

  task automatic test_reset_mid_store();
    clear_state();
    rf[1] <= 32'h0000_0055;
    imem[0] = 32'hAC01_0008;
    data_waitrequest = 1'b1;
    do_reset();
    repeat (4) tick();
    checks++; if (data_write !== 1'b1 || data_address !== 32'h8 || data_writedata !== 32'h55) begin errors++; $display("FAIL sw_mem got %b/%h/%h exp 1/8/55", data_write, data_address, data_writedata); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (data_write !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL sw_async_abort got wr=%b act=%b exp 0/0", data_write, active); end
    tick();
    data_waitrequest = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++; if (instr_read !== 1'b1 || instr_address !== 32'hBFC0_0000) begin errors++; $display("FAIL sw_restart_fetch got %b/%h exp 1/bfc00000", instr_read, instr_address); end
  endtask

  initial begin
    reset_n           = 1'b0;
    instr_waitrequest = 1'b0;
    data_waitrequest  = 1'b0;
    data_readdata     = 32'd0;
    test_reset();
    test_alu_addiu();
    test_lw_wait();
    test_branch_delay_slot();
    test_jr_halt();
    test_addu_zero_dest();
    test_unknown_opcode();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
